// File: rtl/prio_enc8_3_using_sm.sv
// 8-to-3 MSB-first priority encoder with registered index and idle flag.
// A one-flop request-tracking state machine drives idle.
module prio_enc8_3_using_sm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] I,
  output logic [2:0] y,
  output logic       idle
);

  typedef enum logic {
    S_ACTIVE = 1'b0,
    S_IDLE   = 1'b1
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [2:0] enc;

  // Descending if-chain: bits below the first set bit are never examined.
  always_comb begin
    enc = 3'd0;
    if (I[7])      enc = 3'd7;
    else if (I[6]) enc = 3'd6;
    else if (I[5]) enc = 3'd5;
    else if (I[4]) enc = 3'd4;
    else if (I[3]) enc = 3'd3;
    else if (I[2]) enc = 3'd2;
    else if (I[1]) enc = 3'd1;
    else           enc = 3'd0;
  end

  always_comb begin
    nxt = S_IDLE;
    if (I[7] | I[6] | I[5] | I[4] |
        I[3] | I[2] | I[1] | I[0])
      nxt = S_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      y     <= 3'd0;
    end else begin
      state <= nxt;
      y     <= (nxt == S_IDLE) ? 3'd0 : enc;
    end
  end

  // idle is the state flop itself, so the two can never disagree.
  assign idle = (state == S_IDLE);

endmodule

// File: tb/tb_prio_enc8_3_using_sm.sv
// Directed self-checking bench for prio_enc8_3_using_sm.
// Each scenario task drives vectors and checks y/idle one edge later.
module tb_prio_enc8_3_using_sm;

  logic       clk;
  logic       rst_n;
  logic [7:0] I;
  logic [2:0] y;
  logic       idle;

  int errors;
  int checks;

  prio_enc8_3_using_sm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .I     (I),
    .y     (y),
    .idle  (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic [7:0] v);
    @(negedge clk);
    I = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(8'hFF);
    step(8'hFF);
    checks++;
    if (y !== 3'd0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: y=%b idle=%b want y=000 idle=1",
               y, idle);
    end
    rst_n = 1'b1;
    step(8'h00);
    checks++;
    if (y !== 3'd0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: y=%b idle=%b want y=000 idle=1",
               y, idle);
    end
  endtask

  task automatic test_single_hot();
    logic [7:0] vin [4] = '{8'b0000_0001, 8'b0000_0100,
                            8'b0001_0000, 8'b0100_0000};
    logic [2:0] vexp [4] = '{3'b000, 3'b010, 3'b100, 3'b110};
    for (int i = 0; i < 4; i++) begin
      step(vin[i]);
      checks++;
      if (y !== vexp[i] || idle !== 1'b0) begin
        errors++;
        $display("FAIL single_hot[%0d]: I=%b y=%b idle=%b want y=%b idle=0",
                 i, vin[i], y, idle, vexp[i]);
      end
    end
  endtask

  task automatic test_multi_hot();
    logic [7:0] vin [4] = '{8'b0010_0010, 8'b1000_1100,
                            8'b0111_1111, 8'b0000_0011};
    logic [2:0] vexp [4] = '{3'b101, 3'b111, 3'b110, 3'b001};
    for (int i = 0; i < 4; i++) begin
      step(vin[i]);
      checks++;
      if (y !== vexp[i] || idle !== 1'b0) begin
        errors++;
        $display("FAIL multi_hot[%0d]: I=%b y=%b idle=%b want y=%b idle=0",
                 i, vin[i], y, idle, vexp[i]);
      end
    end
  endtask

  task automatic test_dont_care();
    logic [7:0] vin [4] = '{8'b0000_01xx, 8'b1000_xxxx,
                            8'b0000_0111, 8'b1000_1011};
    logic [2:0] vexp [4] = '{3'b010, 3'b111, 3'b010, 3'b111};
    for (int i = 0; i < 4; i++) begin
      step(vin[i]);
      checks++;
      if (y !== vexp[i] || idle !== 1'b0) begin
        errors++;
        $display("FAIL dont_care[%0d]: y=%b idle=%b want y=%b idle=0",
                 i, y, idle, vexp[i]);
      end
      checks++;
      if ($isunknown({y, idle})) begin
        errors++;
        $display("FAIL no_x[%0d]: y=%b idle=%b want known values",
                 i, y, idle);
      end
    end
  endtask

  task automatic test_idle();
    logic [7:0] vin [3] = '{8'b0000_0001, 8'b0000_0000, 8'b0100_0000};
    logic [2:0] vexp [3] = '{3'b000, 3'b000, 3'b110};
    logic       iexp [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(vin[i]);
      checks++;
      if (y !== vexp[i] || idle !== iexp[i]) begin
        errors++;
        $display("FAIL idle_seq[%0d]: y=%b idle=%b want y=%b idle=%b",
                 i, y, idle, vexp[i], iexp[i]);
      end
    end
    step(8'b0100_0000);
    checks++;
    if (y !== 3'b110 || idle !== 1'b0) begin
      errors++;
      $display("FAIL hold_const: y=%b idle=%b want y=110 idle=0",
               y, idle);
    end
  endtask

  task automatic test_mid_reset();
    step(8'b1000_0000);
    checks++;
    if (y !== 3'b111 || idle !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: y=%b idle=%b want y=111 idle=0", y, idle);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 3'b111 || idle !== 1'b0) begin
      errors++;
      $display("FAIL mid_hold: y=%b idle=%b want y=111 idle=0", y, idle);
    end
    @(posedge clk);
    #1;
    checks++;
    if (y !== 3'b000 || idle !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: y=%b idle=%b want y=000 idle=1", y, idle);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (y !== 3'b111 || idle !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: y=%b idle=%b want y=111 idle=0",
               y, idle);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vin [6] = '{8'h00, 8'h80, 8'h01, 8'h08, 8'h00, 8'h20};
    logic [2:0] vexp [6] = '{3'd0, 3'd7, 3'd0, 3'd3, 3'd0, 3'd5};
    logic       iexp [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(vin[i]);
      checks++;
      if (y !== vexp[i] || idle !== iexp[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: I=%h y=%b idle=%b want y=%b idle=%b",
                 i, vin[i], y, idle, vexp[i], iexp[i]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    I      = 8'h00;
    test_reset();
    test_single_hot();
    test_multi_hot();
    test_dont_care();
    test_idle();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
